// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with run control, stall/redirect and debug counters.
// All state advances on the falling edge of i_clk; i_reset is async active-low.
module pc_sequencer #(
    parameter int unsigned      NBITS        = 32,
    parameter logic [NBITS-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      CNT_BITS     = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_step_mode,
    input  logic                i_step,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [NBITS-1:0]    i_redirect_pc,
    input  logic                i_halt,
    output logic [NBITS-1:0]    o_PC,
    output logic [NBITS-1:0]    o_PC_4,
    output logic [NBITS-1:0]    o_PC_8,
    output logic                o_valid,
    output logic [1:0]          o_state,
    output logic [CNT_BITS-1:0] o_cycle_count,
    output logic [CNT_BITS-1:0] o_instr_count
);

    // Clears the low log2(INC) bits so every PC is instruction aligned.
    localparam logic [NBITS-1:0] ALIGN_MASK = ~(NBITS'(INC) - NBITS'(1));
    localparam logic [NBITS-1:0] PC_RESET   = RESET_VECTOR & ALIGN_MASK;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [NBITS-1:0]    pc_q, pc_d;
    logic                valid_q, valid_d;
    logic                step_q;
    logic                step_edge;
    logic                advance_ok;
    logic                cycle_inc;
    logic [CNT_BITS-1:0] cycle_q, instr_q;

    assign step_edge = i_step & ~step_q;

    // State register.
    always_ff @(negedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; halt in RUN/STEP_WAIT is terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = i_step_mode ? ST_STEP : ST_RUN;
            end
            ST_RUN: begin
                if (i_halt)           state_d = ST_HALTED;
                else if (i_step_mode) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (i_halt)            state_d = ST_HALTED;
                else if (!i_step_mode) state_d = ST_RUN;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Datapath next values: PC advance priority is halt > redirect > stall > increment.
    always_comb begin
        pc_d       = pc_q;
        valid_d    = 1'b0;
        cycle_inc  = 1'b0;
        advance_ok = (state_q == ST_RUN) || ((state_q == ST_STEP) && step_edge);
        if ((state_q == ST_RUN) || (state_q == ST_STEP) || ((state_q == ST_IDLE) && i_start)) begin
            cycle_inc = 1'b1;
        end
        if (advance_ok && !i_halt) begin
            if (i_redirect) begin
                pc_d    = i_redirect_pc & ALIGN_MASK;
                valid_d = 1'b1;
            end else if (!i_stall) begin
                pc_d    = pc_q + NBITS'(INC);
                valid_d = 1'b1;
            end
        end
    end

    // PC, fetch-valid, step edge detector and saturating counters.
    always_ff @(negedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q    <= PC_RESET;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            step_q  <= i_step;
            if (cycle_inc && (cycle_q != CNT_MAX)) cycle_q <= cycle_q + CNT_BITS'(1);
            if (valid_d && (instr_q != CNT_MAX))   instr_q <= instr_q + CNT_BITS'(1);
        end
    end

    // Sequential-fetch addresses follow the PC register combinationally.
    always_comb begin
        o_PC          = pc_q;
        o_PC_4        = pc_q + NBITS'(INC);
        o_PC_8        = pc_q + NBITS'(2 * INC);
        o_valid       = valid_q;
        o_state       = state_q;
        o_cycle_count = cycle_q;
        o_instr_count = instr_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed test for pc_sequencer: main 32-bit instance plus a narrow instance
// for address wrap and counter saturation.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk = 1'b1;
    logic        rst;
    logic        start, step_mode, step, stall, redirect, halt;
    logic [31:0] redirect_pc;
    logic [31:0] pc, pc_4, pc_8, cyc, ins;
    logic        valid;
    logic [1:0]  state;

    logic        s_start;
    logic [7:0]  s_pc, s_pc_4, s_pc_8;
    logic        s_valid;
    logic [1:0]  s_state;
    logic [3:0]  s_cyc, s_ins;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .NBITS(32), .RESET_VECTOR(32'h0000_0010), .INC(4), .CNT_BITS(32)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .i_halt(halt),
        .o_PC(pc), .o_PC_4(pc_4), .o_PC_8(pc_8), .o_valid(valid),
        .o_state(state), .o_cycle_count(cyc), .o_instr_count(ins)
    );

    pc_sequencer #(
        .NBITS(8), .RESET_VECTOR(8'hFC), .INC(4), .CNT_BITS(4)
    ) dut_s (
        .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_step_mode(1'b0),
        .i_step(1'b0), .i_stall(1'b0), .i_redirect(1'b0),
        .i_redirect_pc(8'h00), .i_halt(1'b0),
        .o_PC(s_pc), .o_PC_4(s_pc_4), .o_PC_8(s_pc_8), .o_valid(s_valid),
        .o_state(s_state), .o_cycle_count(s_cyc), .o_instr_count(s_ins)
    );

    // Single comparison point for every check.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One active (falling) edge, then settle before sampling.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 0; step_mode = 0; step = 0; stall = 0;
        redirect = 0; halt = 0; redirect_pc = '0; s_start = 0;
        #2 rst = 1'b0;
        #1;
        check("rst_pc",    pc, 32'h10);
        check("rst_pc4",   pc_4, 32'h14);
        check("rst_pc8",   pc_8, 32'h18);
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_cyc",   cyc, 32'd0);
        check("rst_ins",   ins, 32'd0);
        check("s_rst_pc",  32'(s_pc), 32'hFC);

        @(negedge clk); #1;
        rst = 1'b1;
        start = 1;
        tick();
        check("start_state", 32'(state), 32'd1);
        check("start_pc",    pc, 32'h10);
        check("start_valid", 32'(valid), 32'd0);
        check("start_cyc",   cyc, 32'd1);
        start = 0;
        tick();
        check("run1_pc",    pc, 32'h14);
        check("run1_valid", 32'(valid), 32'd1);
        tick();
        check("run2_pc",  pc, 32'h18);
        check("run2_pc4", pc_4, 32'h1C);
        check("run2_pc8", pc_8, 32'h20);
        check("run2_ins", ins, 32'd2);
        check("run2_cyc", cyc, 32'd3);

        // Redirect then stall
        redirect = 1; redirect_pc = 32'h40;
        tick();
        check("redir_pc", pc, 32'h40);
        redirect = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",    pc, 32'h40);
            check("stall_valid", 32'(valid), 32'd0);
        end
        check("stall_cyc", cyc, 32'd7);
        check("stall_ins", ins, 32'd3);
        redirect = 1; redirect_pc = 32'h103;
        tick();
        check("redir_stall_pc",    pc, 32'h100);
        check("redir_stall_valid", 32'(valid), 32'd1);
        check("redir_stall_ins",   ins, 32'd4);
        stall = 0;

        // Enter single-step; this edge still advances (redirect to 0x8)
        redirect_pc = 32'h8; step_mode = 1;
        tick();
        check("enter_step_state", 32'(state), 32'd2);
        check("enter_step_pc",    pc, 32'h8);
        check("enter_step_ins",   ins, 32'd5);
        redirect = 0;
        tick();
        check("stepwait_idle_pc",    pc, 32'h8);
        check("stepwait_idle_valid", 32'(valid), 32'd0);
        step = 1;
        tick();
        check("step1_pc",    pc, 32'hC);
        check("step1_valid", 32'(valid), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("step_hold_pc",  pc, 32'hC);
        check("step_hold_ins", ins, 32'd6);
        step = 0; tick();
        step = 1; tick();
        check("step2_pc", pc, 32'h10);
        step = 0; tick();
        step = 1; tick();
        check("step3_pc",  pc, 32'h14);
        check("step3_ins", ins, 32'd8);
        check("step3_cyc", cyc, 32'd19);

        // Step coinciding with stall is consumed, not queued
        step = 0; tick();
        step = 1; stall = 1; tick();
        check("step_stall_pc",    pc, 32'h14);
        check("step_stall_valid", 32'(valid), 32'd0);
        stall = 0; tick();
        check("step_noqueue_pc", pc, 32'h14);
        step = 0;

        // Back to run: transition edge without a step does not advance
        step_mode = 0;
        tick();
        check("back_run_state", 32'(state), 32'd1);
        check("back_run_pc",    pc, 32'h14);
        tick(); tick(); tick();
        check("pre_halt_pc",  pc, 32'h20);
        check("pre_halt_ins", ins, 32'd11);
        check("pre_halt_cyc", cyc, 32'd26);

        // Halt beats redirect; halted state ignores everything
        halt = 1; redirect = 1; redirect_pc = 32'h80;
        tick();
        check("halt_state", 32'(state), 32'd3);
        check("halt_pc",    pc, 32'h20);
        check("halt_valid", 32'(valid), 32'd0);
        check("halt_cyc",   cyc, 32'd27);
        halt = 0; start = 1; step = 1; step_mode = 1;
        tick(); tick();
        check("halted_state", 32'(state), 32'd3);
        check("halted_pc",    pc, 32'h20);
        check("halted_cyc",   cyc, 32'd27);
        check("halted_ins",   ins, 32'd11);

        // Async reset mid-run
        rst = 0; start = 0; step = 0; step_mode = 0; redirect = 0;
        #2;
        check("halt_rst_state", 32'(state), 32'd0);
        @(negedge clk); #1;
        rst = 1; start = 1;
        tick();
        start = 0; redirect = 1; redirect_pc = 32'h50;
        tick();
        check("mid_pc", pc, 32'h50);
        redirect = 0;
        #2 rst = 0;
        #1;
        check("async_pc",    pc, 32'h10);
        check("async_pc4",   pc_4, 32'h14);
        check("async_state", 32'(state), 32'd0);
        check("async_valid", 32'(valid), 32'd0);
        check("async_cyc",   cyc, 32'd0);
        check("async_ins",   ins, 32'd0);

        // Narrow instance: wrap and saturation
        @(negedge clk); #1;
        rst = 1; s_start = 1;
        tick();
        check("s_start_state", 32'(s_state), 32'd1);
        check("s_fc_pc",  32'(s_pc), 32'hFC);
        check("s_fc_pc4", 32'(s_pc_4), 32'h00);
        check("s_fc_pc8", 32'(s_pc_8), 32'h04);
        s_start = 0;
        tick();
        check("s_wrap_pc",  32'(s_pc), 32'h00);
        check("s_wrap_pc8", 32'(s_pc_8), 32'h08);
        for (int i = 0; i < 20; i++) tick();
        check("s_sat_cyc", 32'(s_cyc), 32'd15);
        check("s_sat_ins", 32'(s_ins), 32'd15);
        check("idle_hold_pc",    pc, 32'h10);
        check("idle_hold_state", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
